// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, id type and round-robin pointer helper for the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned WB_ARB_REQ_NUM = 3;
  localparam int unsigned WB_ARB_ID_W    = 3;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned REG_W          = 32;

  typedef logic [WB_ARB_ID_W-1:0] wb_arb_id_t;

  // Index following g, wrapping n-1 back to 0.
  function automatic wb_arb_id_t rr_next(input wb_arb_id_t g, input int unsigned n);
    logic [WB_ARB_ID_W:0] inc;
    inc = {1'b0, g} + (WB_ARB_ID_W + 1)'(1);
    return (32'(inc) >= n) ? '0 : inc[WB_ARB_ID_W-1:0];
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after start, wrapping modulo NUM_REQ.
module regfile_wb_arbiter_rr_pick
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WB_ARB_REQ_NUM
) (
  input  logic [NUM_REQ-1:0] req,
  input  wb_arb_id_t         start,
  output logic [NUM_REQ-1:0] grant_c,
  output wb_arb_id_t         grant_idx_c,
  output logic               grant_vld_c
);

  logic [NUM_REQ-1:0]   rot;
  logic [WB_ARB_ID_W:0] sum;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    sum         = '0;
    // Rotate so bit 0 is the requester at start; first set bit wins.
    rot = NUM_REQ'({req, req} >> start);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld_c && rot[i]) begin
        grant_vld_c = 1'b1;
        sum         = {1'b0, start} + (WB_ARB_ID_W + 1)'(i);
        grant_idx_c = (32'(sum) >= NUM_REQ) ? WB_ARB_ID_W'(32'(sum) - NUM_REQ)
                                            : sum[WB_ARB_ID_W-1:0];
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      grant_c[j] = grant_vld_c && (grant_idx_c == WB_ARB_ID_W'(j));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback sources.
// WB_ARB_PIPE_PRIO_EN gives requester 0 (pipeline WB) absolute priority.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WB_ARB_REQ_NUM,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic [WB_ARB_ID_W-1:0]    grant_id
);

  wb_arb_id_t         rr_ptr;
  wb_arb_id_t         pick_idx;
  wb_arb_id_t         sel_idx;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] sel_grant;
  logic               pick_vld;
  logic               sel_vld;
  logic               adv_ptr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

`ifdef WB_ARB_PIPE_PRIO_EN
  assign pick_req = req_valid & ~NUM_REQ'(1);
`else
  assign pick_req = req_valid;
`endif

  regfile_wb_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req        (pick_req),
    .start      (rr_ptr),
    .grant_c    (pick_grant),
    .grant_idx_c(pick_idx),
    .grant_vld_c(pick_vld)
  );

  // Final grant: optional pipeline override, then gated off while in reset.
  always_comb begin
    sel_grant = pick_grant;
    sel_idx   = pick_idx;
    sel_vld   = pick_vld;
    adv_ptr   = pick_vld;
`ifdef WB_ARB_PIPE_PRIO_EN
    if (req_valid[0]) begin
      sel_grant = NUM_REQ'(1);
      sel_idx   = '0;
      sel_vld   = 1'b1;
      adv_ptr   = 1'b0;
    end
`endif
    if (!rst) begin
      sel_grant = '0;
      sel_vld   = 1'b0;
      adv_ptr   = 1'b0;
    end
  end

  assign req_ready = sel_grant;

  // One-hot mux of the granted payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write port register; r0 writes are accepted but never enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
    end else begin
      write_en <= sel_vld && (sel_addr != '0);
      if (sel_vld) begin
        write_addr <= sel_addr;
        write_data <= sel_data;
        grant_id   <= sel_idx;
      end
      if (adv_ptr) begin
        rr_ptr <= rr_next(sel_idx, NUM_REQ);
      end
    end
  end

endmodule
